div_iter: RTL

- Parametrised multi-cycle restoring divider for the 5-stage pipeline. One quotient bit per cycle.
- Serves DIV/DIVU: the EX stage issues an operation with a start/ready handshake and stalls until the result returns.
- Generalises the fixed 32-bit divider to any operand width, adds an explicit divide-by-zero flag and adds annulment of an in-flight operation.
- Result is written to HI (remainder) and LO (quotient) by the writeback path.

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter_step.sv | 27 ++
 rtl/div_iter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake levels and the default operand width.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int DivWidthDefault = 32;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit, trial-subtract the divisor and keep
// the difference only when it is non-negative.
module div_iter_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DivWidthDefault
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction in WIDTH+1 bits; the top bit of diff is the sign.
  always_comb begin
    shifted  = {rem_in, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[WIDTH];
    rem_out  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider, one quotient bit per clock. Handles
// signed/unsigned operation, divide-by-zero flagging and annulment of an
// operation in flight. result_o = {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DivWidthDefault,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               dbz_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quot_reg;
  logic             neg_quot_reg;
  logic             neg_rem_reg;

  logic [WIDTH-1:0] rem_next;
  logic             quot_bit_next;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (dividend_reg[WIDTH-1]),
    .divisor      (divisor_reg),
    .rem_out      (rem_next),
    .quot_bit     (quot_bit_next)
  );

  // Operand magnitudes for signed mode and the final sign fix-up values.
  always_comb begin
    op1_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    quot_fixed = neg_quot_reg ? (~quot_reg + 1'b1) : quot_reg;
    rem_fixed  = neg_rem_reg  ? (~rem_reg + 1'b1)  : rem_reg;
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= DivFree;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_o     <= '0;
      ready_o      <= DivResultNotReady;
      dbz_o        <= 1'b0;
    end else begin
      case (state_reg)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            cnt_reg      <= '0;
            dividend_reg <= op1_mag;
            divisor_reg  <= op2_mag;
            rem_reg      <= '0;
            quot_reg     <= '0;
            neg_quot_reg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_reg  <= signed_div_i & opdata1_i[WIDTH-1];
            dbz_o        <= 1'b0;
            state_reg    <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (annul_i) begin
            state_reg <= DivFree;
          end else begin
            dbz_o     <= 1'b1;
            state_reg <= DivEnd;
          end
        end
        DivOn: begin
          ready_o <= DivResultNotReady;
          if (annul_i) begin
            result_o  <= '0;
            state_reg <= DivFree;
          end else if (cnt_reg != CntLast) begin
            rem_reg      <= rem_next;
            quot_reg     <= {quot_reg[WIDTH-2:0], quot_bit_next};
            dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
            cnt_reg      <= cnt_reg + 1'b1;
          end else begin
            // Fix-up: signed overflow (most-negative / -1) wraps naturally.
            result_o  <= {rem_fixed, quot_fixed};
            dbz_o     <= 1'b0;
            state_reg <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
            state_reg <= DivFree;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: state_reg <= DivFree;
      endcase
    end
  end

endmodule
